// File: rtl/bus_dev_port_if.sv
// bus_dev_port_if: host-side and bus-side signals of one bus device port.
interface bus_dev_port_if #(
  parameter int pckg_sz = 16
);
  logic               tx_push;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_full;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_pop;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_valid;
  logic               tx_ovf;
  logic [7:0]         rx_drop_cnt;
  modport slave (
    input  tx_push, tx_data, pop, push, D_push, rx_pop,
    output tx_full, pndng, D_pop, rx_data, rx_valid, tx_ovf, rx_drop_cnt
  );
  modport master (
    output tx_push, tx_data, pop, push, D_push, rx_pop,
    input  tx_full, pndng, D_pop, rx_data, rx_valid, tx_ovf, rx_drop_cnt
  );
endinterface

// File: rtl/bus_dev_port.sv
// bus_dev_port: bus device port with show-ahead TX/RX FIFOs and a saturating RX drop counter.
// Define BUS_DEV_ADDR_FILTER_EN to accept only RX words addressed to id or broadcast.
module bus_dev_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input logic           clk,
  input logic           reset,
  bus_dev_port_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_cnt = cw'(depth);
`ifdef BUS_DEV_ADDR_FILTER_EN
  localparam bit filter_en = 1'b1;
`else
  localparam bit filter_en = 1'b0;
`endif
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
  logic [cw-1:0]      tx_cnt, rx_cnt;
  logic               tx_wr, tx_rd, rx_wr, rx_rd, rx_drop, dest_hit;
  logic               tx_ovf_q;
  logic [7:0]         drop_q;
  assign tx_rd    = bus.pop && tx_cnt != '0;
  assign tx_wr    = bus.tx_push && (tx_cnt != full_cnt || tx_rd);
  assign rx_rd    = bus.rx_pop && rx_cnt != '0;
  assign dest_hit = bus.D_push[pckg_sz-1 -: 8] == id || bus.D_push[pckg_sz-1 -: 8] == broadcast;
  // a same-cycle read frees the slot, so a full FIFO still accepts the write
  assign rx_wr    = bus.push && (dest_hit || !filter_en) && (rx_cnt != full_cnt || rx_rd);
  assign rx_drop  = bus.push && !rx_wr;
  assign bus.D_pop       = tx_mem[tx_rp];
  assign bus.rx_data     = rx_mem[rx_rp];
  assign bus.pndng       = tx_cnt != '0;
  assign bus.tx_full     = tx_cnt == full_cnt;
  assign bus.rx_valid    = rx_cnt != '0;
  assign bus.tx_ovf      = tx_ovf_q;
  assign bus.rx_drop_cnt = drop_q;
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp] <= bus.tx_data;
    if (rx_wr) rx_mem[rx_wp] <= bus.D_push;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      tx_ovf_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      tx_wp    <= tx_wr ? tx_wp + aw'(1) : tx_wp;
      tx_rp    <= tx_rd ? tx_rp + aw'(1) : tx_rp;
      tx_cnt   <= tx_cnt + cw'(tx_wr) - cw'(tx_rd);
      rx_wp    <= rx_wr ? rx_wp + aw'(1) : rx_wp;
      rx_rp    <= rx_rd ? rx_rp + aw'(1) : rx_rp;
      rx_cnt   <= rx_cnt + cw'(rx_wr) - cw'(rx_rd);
      tx_ovf_q <= bus.tx_push && !tx_wr;
      drop_q   <= rx_drop && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
    end
  end
endmodule

// File: tb/tb_bus_dev_port.sv
// tb_bus_dev_port: directed and random stimulus against a queue-based reference model.
module tb_bus_dev_port;
  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h02;
  localparam logic [7:0] BC    = 8'hFF;
`ifdef BUS_DEV_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  always #5 clk = ~clk;
  bus_dev_port_if #(.pckg_sz(16)) bif ();
  bus_dev_port #(.pckg_sz(16), .depth(DEPTH), .id(ID), .broadcast(BC)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );
  logic [15:0] tq[$];
  logic [15:0] rq[$];
  bit          m_ovf;
  int          m_drop;
  bit          hit;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: FIFOs as queues, rules applied in plain order
  always @(posedge clk) begin
    if (reset) begin
      tq.delete();
      rq.delete();
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      m_ovf = bif.tx_push && tq.size() == DEPTH && !bif.pop;
      if (bif.pop && tq.size() > 0) void'(tq.pop_front());
      if (bif.tx_push && tq.size() < DEPTH) tq.push_back(bif.tx_data);
      if (bif.rx_pop && rq.size() > 0) void'(rq.pop_front());
      hit = !FILT || bif.D_push[15:8] == ID || bif.D_push[15:8] == BC;
      if (bif.push) begin
        if (hit && rq.size() < DEPTH) rq.push_back(bif.D_push);
        else if (m_drop < 255) m_drop++;
      end
    end
  end
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pndng", 32'(bif.pndng), 32'(tq.size() != 0));
      chk("tx_full", 32'(bif.tx_full), 32'(tq.size() == DEPTH));
      chk("tx_ovf", 32'(bif.tx_ovf), 32'(m_ovf));
      chk("rx_valid", 32'(bif.rx_valid), 32'(rq.size() != 0));
      chk("rx_drop_cnt", 32'(bif.rx_drop_cnt), 32'(m_drop));
      if (tq.size() != 0) chk("D_pop", 32'(bif.D_pop), 32'(tq[0]));
      if (rq.size() != 0) chk("rx_data", 32'(bif.rx_data), 32'(rq[0]));
    end
  end
  task automatic tick(input bit tp = 0, input logic [15:0] td = '0, input bit p = 0,
                      input bit ps = 0, input logic [15:0] dp = '0, input bit rp = 0);
    bif.tx_push = tp;
    bif.tx_data = td;
    bif.pop     = p;
    bif.push    = ps;
    bif.D_push  = dp;
    bif.rx_pop  = rp;
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  logic [15:0] w[DEPTH];
  logic [15:0] exp45[$];
  int          tp_pct, p_pct, ps_pct, rp_pct;
  initial begin
    tick();
    do_reset();
    mon_en = 1'b1;
    chk("reset_pndng", 32'(bif.pndng), 32'd0);
    chk("reset_rx_valid", 32'(bif.rx_valid), 32'd0);
    chk("reset_drop", 32'(bif.rx_drop_cnt), 32'd0);
    tick(1, 16'h0312);
    chk("single_pndng", 32'(bif.pndng), 32'd1);
    chk("single_D_pop", 32'(bif.D_pop), 32'h0312);
    tick(0, 0, 1);
    chk("single_empty", 32'(bif.pndng), 32'd0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = 16'($urandom);
      tick(1, w[i]);
    end
    tick(1, 16'hBEEF);
    chk("ovf_full", 32'(bif.tx_full), 32'd1);
    chk("ovf_pulse", 32'(bif.tx_ovf), 32'd1);
    tick();
    chk("ovf_one_cycle", 32'(bif.tx_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("order_D_pop", 32'(bif.D_pop), 32'(w[i]));
      tick(0, 0, 1);
    end
    chk("drained", 32'(bif.pndng), 32'd0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1, 16'($urandom));
    tick(1, 16'hAAAA, 1);
    chk("full_pp_full", 32'(bif.tx_full), 32'd1);
    chk("full_pp_ovf", 32'(bif.tx_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("full_pp_last", 32'(bif.D_pop), 32'hAAAA);
      tick(0, 0, 1);
    end
    do_reset();
    tick(1, 16'h1111, 1);
    chk("empty_pp_pndng", 32'(bif.pndng), 32'd1);
    chk("empty_pp_data", 32'(bif.D_pop), 32'h1111);
    do_reset();
    exp45 = FILT ? '{16'h02AB, 16'hFF01} : '{16'h02AB, 16'hFF01, 16'h0555};
    tick(0, 0, 0, 1, 16'h02AB);
    tick(0, 0, 0, 1, 16'hFF01);
    tick(0, 0, 0, 1, 16'h0555);
    chk("filter_drop", 32'(bif.rx_drop_cnt), FILT ? 32'd1 : 32'd0);
    foreach (exp45[i]) begin
      chk("filter_valid", 32'(bif.rx_valid), 32'd1);
      chk("filter_data", 32'(bif.rx_data), 32'(exp45[i]));
      tick(0, 0, 0, 0, 0, 1);
    end
    chk("filter_empty", 32'(bif.rx_valid), 32'd0);
    do_reset();
    for (int i = 0; i < DEPTH + 300; i++) tick(0, 0, 0, 1, {ID, 8'(i)});
    chk("drop_sat", 32'(bif.rx_drop_cnt), 32'hFF);
    chk("drop_sat_valid", 32'(bif.rx_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 16'h5000 + 16'(i));
    reset = 1'b1;
    tick(1, 16'h5555, 1, 1, {ID, 8'h77}, 1);
    reset = 1'b0;
    chk("rst_mid_pndng", 32'(bif.pndng), 32'd0);
    chk("rst_mid_full", 32'(bif.tx_full), 32'd0);
    chk("rst_mid_ovf", 32'(bif.tx_ovf), 32'd0);
    tick(1, 16'h1234);
    chk("rst_mid_new", 32'(bif.D_pop), 32'h1234);
    tick(0, 0, 1);
    chk("rst_mid_empty", 32'(bif.pndng), 32'd0);
    do_reset();
    for (int b = 0; b < 20; b++) begin
      tp_pct = $urandom_range(10, 90);
      p_pct  = $urandom_range(10, 90);
      ps_pct = $urandom_range(10, 90);
      rp_pct = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++) begin
        logic [7:0] dest;
        int sel = $urandom_range(0, 3);
        dest = sel == 0 ? ID : sel == 1 ? BC : 8'($urandom);
        tick($urandom_range(0, 99) < tp_pct, 16'($urandom), $urandom_range(0, 99) < p_pct,
             $urandom_range(0, 99) < ps_pct, {dest, 8'($urandom)}, $urandom_range(0, 99) < rp_pct);
      end
      if (b == 10) do_reset();
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
